// File: rtl/wb_retire_queue_pkg.sv
// wb_retire_queue_pkg: shared width constants for the writeback retire queue.
package wb_retire_queue_pkg;
  localparam int XLEN_DEF = 64;  // default data width
  localparam int REG_AW   = 5;   // register address width
  localparam int CSR_AW   = 12;  // CSR address width

  // Index width that stays legal (>=1 bit) for single-element ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_bundle_fifo.sv
// wb_bundle_fifo: DEPTH-entry retire-bundle store with pointers, count and
// per-lane valid mask. All entries are exposed so the top can forward from them.
module wb_bundle_fifo
  import wb_retire_queue_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int LANES = 2,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    push_i,
  input  logic                                    pop_i,
  input  logic [LANES-1:0][REG_AW-1:0]            rd_addr_i,
  input  logic [LANES-1:0][XLEN-1:0]              rd_data_i,
  input  logic [LANES-1:0]                        rd_we_i,
  input  logic [CSR_AW-1:0]                       csr_addr_i,
  input  logic [XLEN-1:0]                         csr_data_i,
  input  logic                                    csr_we_i,
  output logic                                    ready_o,
  output logic [CW-1:0]                           count_o,
  output logic [PW-1:0]                           rd_ptr_o,
  output logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] addr_o,
  output logic [DEPTH-1:0][LANES-1:0][XLEN-1:0]   data_o,
  output logic [DEPTH-1:0][LANES-1:0]             vmask_o,
  output logic [DEPTH-1:0][CSR_AW-1:0]            csr_addr_o,
  output logic [DEPTH-1:0][XLEN-1:0]              csr_data_o,
  output logic [DEPTH-1:0]                        csr_we_o
);
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;

  // Full refuses a push even if the head pops in the same cycle.
  assign ready_o  = count_q < CW'(DEPTH);
  assign push_ok  = push_i & ready_o;
  assign count_o  = count_q;
  assign rd_ptr_o = rd_ptr_q;

  // Pointers wrap naturally (DEPTH is a power of two); pop only arrives when non-empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_i);
    end
  end

  // Control bits: a lane is valid only if enabled and not targeting x0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vmask_o  <= '0;
      csr_we_o <= '0;
    end else if (push_ok) begin
      for (int k = 0; k < LANES; k++)
        vmask_o[wr_ptr_q][k] <= rd_we_i[k] && (rd_addr_i[k] != '0);
      csr_we_o[wr_ptr_q] <= csr_we_i;
    end
  end

  // Payload storage; qualified by the control bits so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_o[wr_ptr_q]     <= rd_addr_i;
      data_o[wr_ptr_q]     <= rd_data_i;
      csr_addr_o[wr_ptr_q] <= csr_addr_i;
      csr_data_o[wr_ptr_q] <= csr_data_i;
    end
  end
endmodule

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: buffers retire bundles and drains them one lane per cycle
// onto the regfile/CSR write ports, with youngest-wins result forwarding.
// Optional feature macro: WB_FWD_EN (forwarding comparators; tied off otherwise).
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int NRP   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    stall_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*REG_AW-1:0] rd_addr_i,
  input  logic [LANES*XLEN-1:0]   rd_data_i,
  input  logic [LANES-1:0]        rd_we_i,
  input  logic [CSR_AW-1:0]       csr_addr_i,
  input  logic [XLEN-1:0]         csr_data_i,
  input  logic                    csr_we_i,
  output logic [REG_AW-1:0]       rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  output logic                    rd_we_o,
  output logic [CSR_AW-1:0]       csr_addr_o,
  output logic [XLEN-1:0]         csr_data_o,
  output logic                    csr_we_o,
  input  logic [NRP*REG_AW-1:0]   fwd_raddr_i,
  output logic [NRP-1:0]          fwd_hit_o,
  output logic [NRP*XLEN-1:0]     fwd_data_o,
  output logic                    busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = idx_w(LANES);

  logic [CW-1:0]                           count;
  logic [PW-1:0]                           rd_ptr;
  logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] q_addr;
  logic [DEPTH-1:0][LANES-1:0][XLEN-1:0]   q_data;
  logic [DEPTH-1:0][LANES-1:0]             q_vmask;
  logic [DEPTH-1:0][CSR_AW-1:0]            q_csr_addr;
  logic [DEPTH-1:0][XLEN-1:0]              q_csr_data;
  logic [DEPTH-1:0]                        q_csr_we;

  logic [LW-1:0] lane_q, sel;
  logic          found, more, first, drain, pop;

  wb_bundle_fifo #(.XLEN(XLEN), .LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .clk_i, .rst_ni,
    .push_i(in_valid_i), .pop_i(pop),
    .rd_addr_i, .rd_data_i, .rd_we_i, .csr_addr_i, .csr_data_i, .csr_we_i,
    .ready_o(in_ready_o), .count_o(count), .rd_ptr_o(rd_ptr),
    .addr_o(q_addr), .data_o(q_data), .vmask_o(q_vmask),
    .csr_addr_o(q_csr_addr), .csr_data_o(q_csr_data), .csr_we_o(q_csr_we)
  );

  // Pick the lowest valid head lane at or above lane_q; note whether more remain.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    sel   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (q_vmask[rd_ptr][k] && (k >= int'(lane_q))) begin
        if (!found) begin
          found = 1'b1;
          sel   = LW'(k);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  // lane_q only returns to 0 on pop, so 0 marks the bundle's first drain cycle.
  assign first  = (lane_q == '0);
  assign drain  = !stall_i && (count != '0);
  assign pop    = drain && !(found && more);
  assign busy_o = (count != '0) || rd_we_o || csr_we_o;

  // Output registers and lane sequencer; everything holds under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      rd_we_o    <= 1'b0;
      csr_addr_o <= '0;
      csr_data_o <= '0;
      csr_we_o   <= 1'b0;
      lane_q     <= '0;
    end else if (!stall_i) begin
      if (drain) begin
        rd_we_o  <= found;
        csr_we_o <= first && q_csr_we[rd_ptr];
        if (found) begin
          rd_addr_o <= q_addr[rd_ptr][sel];
          rd_data_o <= q_data[rd_ptr][sel];
        end
        if (first) begin
          csr_addr_o <= q_csr_addr[rd_ptr];
          csr_data_o <= q_csr_data[rd_ptr];
        end
        lane_q <= (found && more) ? sel + 1'b1 : '0;
      end else begin
        rd_we_o  <= 1'b0;
        csr_we_o <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest (output reg, then queue age/lane order); last match wins.
  for (genvar p = 0; p < NRP; p++) begin : g_fwd
    logic [REG_AW-1:0] raddr;
    logic [PW-1:0]     idx;
    logic              hit;
    logic [XLEN-1:0]   data;
    assign raddr = fwd_raddr_i[p*REG_AW +: REG_AW];

    // Youngest-wins priority search for read port p.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (rd_we_o && (rd_addr_o == raddr)) begin
        hit  = 1'b1;
        data = rd_data_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (CW'(i) < count) begin
          for (int k = 0; k < LANES; k++) begin
            if (q_vmask[idx][k] && (q_addr[idx][k] == raddr)) begin
              hit  = 1'b1;
              data = q_data[idx][k];
            end
          end
        end
      end
      if (raddr == '0) begin
        hit  = 1'b0;
        data = '0;
      end
    end

    assign fwd_hit_o[p]               = hit;
    assign fwd_data_o[p*XLEN +: XLEN] = data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_raddr_i;
  assign fwd_hit_o  = '0;
  assign fwd_data_o = '0;
`endif
endmodule
